// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display path: the glyph table
// used by both the hex encoder and the capture monitor, the capture FSM
// state encoding and the default glitch-filter length.
package seven_segment_pkg;

   // Segment bit order is {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h58;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   // Number of identical consecutive samples before a digit is trusted.
   localparam int DEFAULT_STABLE_CYCLES = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational seven-segment glyph decoder: maps a segment pattern back to
// the hex nibble it displays, flagging any pattern that is not a hex glyph.
module seven_segment_decode
   import seven_segment_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       legal
);

   // Reverse lookup of the glyph table; blank and partial glyphs are illegal.
   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      case (seg)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Monitors a scanned, multiplexed seven-segment bus and recovers the hex
// value being displayed. Each digit must hold a steady pattern for
// STABLE_CYCLES edges before it is committed; once every digit has been
// committed the assembled frame is published on o_VALUE.
module seven_segment_capture
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int CNT_W         = 8
)
(
   input  logic                    i_CLK,
   input  logic                    i_RST,
   input  logic [6:0]              i_SEG,
   input  logic [NUM_DIGITS-1:0]   i_DIG_SEL,
   output logic [4*NUM_DIGITS-1:0] o_VALUE,
   output logic                    o_VALID,
   output logic                    o_FRAME,
   output logic                    o_ERR,
   output logic [NUM_DIGITS-1:0]   o_DIGIT_VALID
);

   localparam int SAMP_W = NUM_DIGITS + 7;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [SAMP_W-1:0]       sample_q;
   logic [SAMP_W-1:0]       next_sample;
   logic [NUM_DIGITS-1:0]   samp_sel;
   logic [6:0]              samp_seg;
   logic                    same;
   logic                    next_onehot;
   logic [3:0]              nibble;
   logic                    legal;
   logic [IDX_W-1:0]        digit_idx;
   logic                    commit;
   logic [CNT_W-1:0]        stable_cnt;
   state_t                  state_q;
   logic [4*NUM_DIGITS-1:0] shadow_q;
   logic [4*NUM_DIGITS-1:0] shadow_upd;
   logic [NUM_DIGITS-1:0]   dv_upd;

   // The incoming bus word is compared against the registered one, so the
   // sample register doubles as the "previous sample" for the glitch filter.
   assign next_sample = {i_DIG_SEL, i_SEG};
   assign samp_sel    = sample_q[SAMP_W-1:7];
   assign samp_seg    = sample_q[6:0];
   assign same        = (next_sample == sample_q);
   assign next_onehot = $onehot(i_DIG_SEL);

   // A commit happens when the settle count is full and the pattern is
   // still unchanged on this edge.
   assign commit = (state_q == SETTLE) && same &&
                   (stable_cnt == CNT_W'(STABLE_CYCLES - 1));

   seven_segment_decode u_decode (
      .seg    (samp_seg),
      .nibble (nibble),
      .legal  (legal)
   );

   // Convert the one-hot select of the settled sample into a digit index.
   always_comb begin
      digit_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (samp_sel[i]) begin
            digit_idx = IDX_W'(i);
         end
      end
   end

   // Shadow with the nibble being committed this cycle merged in, so a frame
   // completing now publishes its final digit too.
   always_comb begin
      shadow_upd = shadow_q;
      shadow_upd[int'(digit_idx) * 4 +: 4] = nibble;
      dv_upd = o_DIGIT_VALID | samp_sel;
   end

   // Register the raw bus every cycle.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         sample_q <= '0;
      end else begin
         sample_q <= next_sample;
      end
   end

   // Settle/hold FSM plus digit commit, error and frame assembly.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q       <= IDLE;
         stable_cnt    <= '0;
         shadow_q      <= '0;
         o_VALUE       <= '0;
         o_VALID       <= 1'b0;
         o_FRAME       <= 1'b0;
         o_ERR         <= 1'b0;
         o_DIGIT_VALID <= '0;
      end else begin
         o_FRAME <= 1'b0;
         o_ERR   <= 1'b0;
         case (state_q)
            IDLE: begin
               stable_cnt <= '0;
               if (next_onehot) begin
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (!same) begin
                  stable_cnt <= '0;
                  state_q    <= next_onehot ? SETTLE : IDLE;
               end else if (commit) begin
                  stable_cnt <= '0;
                  state_q    <= HOLD;
                  if (legal) begin
                     shadow_q <= shadow_upd;
                     if (&dv_upd) begin
                        o_VALUE       <= shadow_upd;
                        o_FRAME       <= 1'b1;
                        o_VALID       <= 1'b1;
                        o_DIGIT_VALID <= '0;
                     end else begin
                        o_DIGIT_VALID <= dv_upd;
                     end
                  end else begin
                     o_ERR         <= 1'b1;
                     o_DIGIT_VALID <= o_DIGIT_VALID & ~samp_sel;
                  end
               end else begin
                  stable_cnt <= stable_cnt + 1'b1;
               end
            end
            HOLD: begin
               stable_cnt <= '0;
               if (!same) begin
                  state_q <= next_onehot ? SETTLE : IDLE;
               end
            end
            default: begin
               stable_cnt <= '0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: full scans, glitch filtering,
// illegal glyphs, static holds, multi-hot selects and reset mid-frame.
module tb_seven_segment_capture;

   logic        i_CLK;
   logic        i_RST;
   logic [6:0]  i_SEG;
   logic [3:0]  i_DIG_SEL;
   logic [15:0] o_VALUE;
   logic        o_VALID;
   logic        o_FRAME;
   logic        o_ERR;
   logic [3:0]  o_DIGIT_VALID;

   int checks;
   int failures;
   int frame_count;
   int err_count;

   seven_segment_capture #(
      .NUM_DIGITS    (4),
      .STABLE_CYCLES (4),
      .CNT_W         (8)
   ) dut (
      .i_CLK         (i_CLK),
      .i_RST         (i_RST),
      .i_SEG         (i_SEG),
      .i_DIG_SEL     (i_DIG_SEL),
      .o_VALUE       (o_VALUE),
      .o_VALID       (o_VALID),
      .o_FRAME       (o_FRAME),
      .o_ERR         (o_ERR),
      .o_DIGIT_VALID (o_DIGIT_VALID)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial i_CLK = 1'b0;
   always #5 i_CLK = ~i_CLK;

   // Count frame and error pulses shortly after each rising edge.
   initial begin
      frame_count = 0;
      err_count   = 0;
   end
   always @(posedge i_CLK) begin
      #2;
      if (o_FRAME === 1'b1) frame_count++;
      if (o_ERR === 1'b1) err_count++;
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Present one bus word and hold it for the given number of rising edges,
   // returning on a falling edge.
   task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg,
                                input int cycles);
      i_DIG_SEL = sel;
      i_SEG     = seg;
      repeat (cycles) @(negedge i_CLK);
   endtask

   // Assert reset partway through a low clock phase and release it later.
   task automatic pulseReset();
      #2 i_RST = 1'b1;
      #1;
      checkOutput("rst_value", 32'(o_VALUE), 32'h0);
      checkOutput("rst_valid", 32'(o_VALID), 32'h0);
      checkOutput("rst_frame", 32'(o_FRAME), 32'h0);
      checkOutput("rst_err",   32'(o_ERR),   32'h0);
      checkOutput("rst_dv",    32'(o_DIGIT_VALID), 32'h0);
      @(negedge i_CLK);
      i_RST = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      i_RST     = 1'b0;
      i_SEG     = 7'h00;
      i_DIG_SEL = 4'b0000;
      repeat (2) @(negedge i_CLK);

      // Asynchronous reset, then idle with no digit selected.
      pulseReset();
      applyStimulus(4'b0000, 7'h00, 5);
      checkOutput("idle_valid", 32'(o_VALID), 32'h0);
      checkOutput("idle_dv", 32'(o_DIGIT_VALID), 32'h0);

      // Full scan of 1A3F; last digit checked edge by edge around the commit.
      applyStimulus(4'b0001, 7'h71, 8);
      checkOutput("scan_dv0", 32'(o_DIGIT_VALID), 32'h1);
      applyStimulus(4'b0010, 7'h4F, 8);
      applyStimulus(4'b0100, 7'h77, 8);
      applyStimulus(4'b1000, 7'h06, 4);
      checkOutput("scan_pre_frames", 32'(frame_count), 32'd0);
      checkOutput("scan_pre_dv", 32'(o_DIGIT_VALID), 32'h7);
      applyStimulus(4'b1000, 7'h06, 1);
      checkOutput("scan_frame_pulse", 32'(o_FRAME), 32'h1);
      checkOutput("scan_value", 32'(o_VALUE), 32'h1A3F);
      applyStimulus(4'b1000, 7'h06, 3);
      checkOutput("scan_frame_after", 32'(o_FRAME), 32'h0);
      checkOutput("scan_frames", 32'(frame_count), 32'd1);
      checkOutput("scan_valid", 32'(o_VALID), 32'h1);
      checkOutput("scan_dv_clr", 32'(o_DIGIT_VALID), 32'h0);

      // Glitch: a short 1 on digit 0 must lose to the steady 2.
      applyStimulus(4'b0000, 7'h00, 2);
      applyStimulus(4'b0001, 7'h06, 2);
      applyStimulus(4'b0001, 7'h5B, 6);
      checkOutput("glitch_dv", 32'(o_DIGIT_VALID), 32'h1);
      checkOutput("glitch_err", 32'(err_count), 32'd0);
      applyStimulus(4'b0010, 7'h6D, 8);
      applyStimulus(4'b0100, 7'h7C, 8);
      applyStimulus(4'b1000, 7'h58, 8);
      checkOutput("glitch_frames", 32'(frame_count), 32'd2);
      checkOutput("glitch_value", 32'(o_VALUE), 32'hCB52);

      // Illegal blank glyph on digit 1 revokes its earlier capture.
      applyStimulus(4'b0010, 7'h4F, 8);
      checkOutput("illegal_pre_dv", 32'(o_DIGIT_VALID), 32'h2);
      applyStimulus(4'b0010, 7'h00, 6);
      checkOutput("illegal_err", 32'(err_count), 32'd1);
      checkOutput("illegal_dv", 32'(o_DIGIT_VALID), 32'h0);
      checkOutput("illegal_frames", 32'(frame_count), 32'd2);
      checkOutput("illegal_value", 32'(o_VALUE), 32'hCB52);

      // Multi-hot select is ignored; a long static hold commits once.
      applyStimulus(4'b0011, 7'h3F, 20);
      checkOutput("multihot_dv", 32'(o_DIGIT_VALID), 32'h0);
      checkOutput("multihot_err", 32'(err_count), 32'd1);
      applyStimulus(4'b0001, 7'h79, 8);
      applyStimulus(4'b1000, 7'h5E, 8);
      applyStimulus(4'b0010, 7'h66, 8);
      checkOutput("hold_pre_dv", 32'(o_DIGIT_VALID), 32'hB);
      applyStimulus(4'b0100, 7'h7F, 100);
      checkOutput("hold_frames", 32'(frame_count), 32'd3);
      checkOutput("hold_value", 32'(o_VALUE), 32'hD84E);
      checkOutput("hold_dv", 32'(o_DIGIT_VALID), 32'h0);

      // Reset in the middle of a frame, then a clean rescan.
      applyStimulus(4'b0000, 7'h00, 2);
      applyStimulus(4'b0001, 7'h71, 8);
      applyStimulus(4'b0010, 7'h4F, 8);
      checkOutput("midrst_pre_dv", 32'(o_DIGIT_VALID), 32'h3);
      i_DIG_SEL = 4'b0000;
      i_SEG     = 7'h00;
      pulseReset();
      applyStimulus(4'b0001, 7'h71, 8);
      applyStimulus(4'b0010, 7'h4F, 8);
      applyStimulus(4'b0100, 7'h77, 8);
      checkOutput("rescan_valid_pre", 32'(o_VALID), 32'h0);
      applyStimulus(4'b1000, 7'h06, 8);
      checkOutput("rescan_value", 32'(o_VALUE), 32'h1A3F);
      checkOutput("rescan_valid", 32'(o_VALID), 32'h1);
      checkOutput("rescan_frames", 32'(frame_count), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Reads a multiplexed, scanned 7-segment display bus (segment lines plus one-hot digit selects) and recovers the hexadecimal value shown.
- Inverse of the hex-to-segment encoder: decodes each settled digit pattern back to a nibble, then assembles a full frame of NUM_DIGITS nibbles.
- Used as an on-chip monitor and self-check of display output, so the display path can be verified against the ALU result.

Parameters:
- NUM_DIGITS, 4: number of scanned digits; o_VALUE width is 4*NUM_DIGITS.
- STABLE_CYCLES, 4: consecutive identical samples needed before a digit is committed (glitch filter); minimum 2.
- CNT_W, 8: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- i_CLK  input  1  sole clock; all state on rising edge.
- i_RST  input  1  asynchronous, active-high reset.
- i_SEG  input  7  segment lines, active-high; bit6..bit0 = g,f,e,d,c,b,a.
- i_DIG_SEL  input  NUM_DIGITS  one-hot, active-high digit enable; bit i = digit i.
- o_VALUE  output  4*NUM_DIGITS  last completed frame; digit i in bits [4i+3:4i].
- o_VALID  output  1  high once any frame has completed since reset; sticky.
- o_FRAME  output  1  one-cycle pulse in the cycle o_VALUE updates.
- o_ERR  output  1  one-cycle pulse when a stable, selected pattern is not a legal hex glyph.
- o_DIGIT_VALID  output  NUM_DIGITS  digits captured so far in the current frame.

Behaviour:
- Reset (async, i_RST=1): o_VALUE=0, o_VALID=0, o_FRAME=0, o_ERR=0, o_DIGIT_VALID=0, sample register=0, counter=0, state=IDLE. Reset mid-frame discards all partial capture.
- Input stage: {i_DIG_SEL, i_SEG} registered every cycle into a sample register. The previous sample is kept for comparison.
- Legal glyph table (i_SEG hex -> nibble): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 58->C, 5E->D, 79->E, 71->F. Every other pattern, including 00 (blank), is illegal.
- FSM states:
  - IDLE: sampled select is not exactly one-hot (zero or multi-hot). Counter=0, no commit, no error. Goes to SETTLE when the sample is one-hot.
  - SETTLE: if the sample equals the previous sample, the counter increments. Any change resets the counter to 0 and stays in SETTLE, or goes to IDLE if the new sample is not one-hot. When the counter reaches STABLE_CYCLES-1 and the next sample is still equal, commit and go to HOLD.
  - HOLD: pattern already committed. Any change in the sample goes to SETTLE (or IDLE) with counter=0. A long static hold commits exactly once.
- Commit timing: if inputs are constant across edges k .. k+STABLE_CYCLES, commit effects are visible after edge k+STABLE_CYCLES.
- Commit of a legal glyph on digit i: the shadow nibble for digit i is written and o_DIGIT_VALID[i] is set. Re-commit of an already-set digit overwrites the nibble.
- Commit of an illegal glyph on digit i: o_ERR pulses, o_DIGIT_VALID[i] is cleared, and the shadow nibble is unchanged.
- Frame completion: in the commit cycle where o_DIGIT_VALID would become all ones:
  - o_VALUE loads the shadow, including the nibble committed that cycle.
  - o_FRAME pulses and o_VALID sets.
  - o_DIGIT_VALID clears to 0 in the same cycle.
- Digit order within a frame is arbitrary; scan direction does not matter.

Decomposition:
- Shared package (seven_segment_pkg): the 16 glyph constants SEG_0..SEG_F (shared with the encoder), FSM state encoding IDLE/SETTLE/HOLD, and the default STABLE_CYCLES.
- One combinational sub-module, seven_segment_decode: 7-bit pattern -> 4-bit nibble plus legal flag. It is reusable as a standalone checker.

Test Plan:
- Reset: assert i_RST asynchronously mid-cycle -> all outputs 0 immediately; state stays IDLE with i_DIG_SEL=0.
- Full scan: sel 0001/seg 71, 0010/4F, 0100/77, 1000/06, each held 8 cycles -> single o_FRAME pulse after the 4th digit commits (4 cycles after its first edge); o_VALUE=16'h1A3F; o_VALID=1; o_DIGIT_VALID=0.
- Glitch filter: digit 0 shows 06 for 2 cycles, then 5B for 6 cycles -> only 2 committed; nibble 0 = 2; no o_ERR.
- Illegal glyph: digit 1 shows 00 for 6 cycles -> one o_ERR pulse; o_DIGIT_VALID[1]=0; no frame; o_VALUE unchanged.
- Static hold and multi-hot: digit 2 shows 7F for 100 cycles -> exactly one commit. Sel 0011 with seg 3F for 20 cycles -> no commit, no o_ERR.
- Reset mid-frame: after 2 digits are captured (o_DIGIT_VALID=0011), pulse i_RST -> o_DIGIT_VALID=0, o_VALID=0, o_VALUE=0. A full rescan of 1A3F then yields a frame with o_VALUE=16'h1A3F.
